vx_tex_dcr_seq: RTL
===================

Name: vx_tex_dcr_seq

Overview:
- Sequencer that programs one texture stage's DCR state from a single packed descriptor request.
- It issues the stage-select write, then baseaddr, format, filter, wrap, logdim and the mip offsets, one DCR write per cycle.
- It sits between the texture-setup request source and the DCR bus feeding the per-stage texture DCR block, and shares that bus with host DCR writes; host writes have priority.

Parameters:
NUM_STAGES, 1, number of texture stages; STAGE_W = max(1, CLOG2(NUM_STAGES)).
NUM_MIPS, `VX_TEX_LOD_MAX+1, number of mip offset registers per stage.
MIPC_W, CLOG2(NUM_MIPS+1), width of mip count field.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  descriptor valid
req_ready  out  1  descriptor accepted when valid&&ready
req_stage  in  STAGE_W  target stage
req_baseaddr  in  TEX_ADDR_BITS  texture base address
req_format  in  TEX_FORMAT_BITS  format
req_filter  in  TEX_FILTER_BITS  filter
req_wraps  in  2xTEX_WRAP_BITS  wrap u/v
req_logdims  in  2xVX_TEX_LOD_BITS  log2 width/height
req_mipoff  in  NUM_MIPSxTEX_MIPOFF_BITS  mip offsets, index 0 at LSBs
req_mip_count  in  MIPC_W  number of mip offsets to write; values >NUM_MIPS are clamped to NUM_MIPS
host_write_valid  in  1  host DCR write
host_write_addr  in  VX_DCR_ADDR_WIDTH  host DCR address
host_write_data  in  VX_DCR_DATA_WIDTH  host DCR data
dcr_write_valid  out  1  DCR bus write strobe
dcr_write_addr  out  VX_DCR_ADDR_WIDTH  DCR bus address
dcr_write_data  out  VX_DCR_DATA_WIDTH  DCR bus data
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, sequence complete

Behaviour:
- Clock/reset: clk and reset_n, one clock domain; reset is asynchronous, active-low.
- Reset values: state=IDLE, req_ready=1, busy=0, done=0, mip index=0, restage=0. Registered DCR outputs reset to dcr_write_valid=0, addr=0, data=0.
- Reset mid-sequence aborts immediately. No further writes are issued, and the downstream stage's partial contents are undefined.
- All DCR outputs are registered: a write selected in cycle N appears on the bus in cycle N+1.
- FSM states: IDLE, STAGE, ADDR, FORMAT, FILTER, WRAP, LOGDIM, MIP, DONE.
- IDLE: req_ready=1. On req_valid, capture all req_* fields (mip count clamped), clear the mip index, go to STAGE, and set busy=1.
- Writes issued by state (addresses are the VX_DCR_TEX_* constants, data zero-extended):
  - STAGE: VX_DCR_TEX_STAGE, data = stage.
  - ADDR: VX_DCR_TEX_ADDR, data = baseaddr.
  - FORMAT: VX_DCR_TEX_FORMAT, data = format.
  - FILTER: VX_DCR_TEX_FILTER, data = filter.
  - WRAP: VX_DCR_TEX_WRAP, wraps[0] at bit 0, wraps[1] at bit 16, other bits 0.
  - LOGDIM: VX_DCR_TEX_LOGDIM, logdims[0] at bit 0, logdims[1] at bit 16.
  - MIP: VX_DCR_TEX_MIPOFF(idx), data = mipoff[idx]. idx increments per issued write; leave MIP after idx == count-1.
- After LOGDIM, go to MIP if count>0, else DONE.
- DONE: done=1 for one cycle, busy=0 and req_ready=1 from the next cycle (back to IDLE). No request is accepted in the DONE cycle.
- Arbitration: when host_write_valid=1, the host write is forwarded to the bus that slot. The sequencer stalls and holds its state and idx.
- If a host write is forwarded while busy and its address is VX_DCR_TEX_STAGE, set restage. In the next free slot, re-issue the STAGE write (captured stage), then clear restage and resume the interrupted state. An interrupted STAGE state needs no extra write.
- Host writes in IDLE or DONE pass through with no side effects.
- Uninterrupted latency: the accept cycle is followed by 6+count issue cycles. The first bus write appears 2 cycles after accept; done asserts the cycle after the last write is issued.
- Throughput: one write per cycle, no gaps without a host write.

Test Plan:
- NUM_STAGES=4, stage=2, base=0x1000, format=3, filter=1, wraps={1,2}, logdims={8,9}, count=2 -> bus sequence STAGE=2, ADDR=0x1000, FORMAT=3, FILTER=1, WRAP=0x00020001, LOGDIM=0x00090008, MIPOFF(0), MIPOFF(1), contiguous; done pulses once; busy high exactly 8 issue cycles.
- count=0 -> exactly 6 writes, no MIPOFF address; count=NUM_MIPS+3 -> exactly NUM_MIPS MIPOFF writes, idx 0..NUM_MIPS-1.
- Host write to VX_DCR_TEX_FORMAT during FILTER state -> host write appears on the bus, the sequencer's FILTER write follows next cycle, no extra STAGE write, total writes = 7+count.
- Host write STAGE=0 during the WRAP state -> host write, then STAGE=2 re-issued, then WRAP; final sequence order verified.
- req_valid held high through a sequence -> second descriptor accepted only in the IDLE cycle after DONE; no overlap of writes.
- reset_n asserted low mid-MIP -> dcr_write_valid=0, busy=0, req_ready=1 immediately (asynchronously); after release, a new request runs the full sequence from STAGE.

Source files
------------

// File: rtl/vx_tex_dcr_seq_if.sv
// Bundles the descriptor handshake, host DCR write port, and outgoing DCR bus
// of the texture DCR sequencer. Widths must match the sequencer's parameters.
interface vx_tex_dcr_seq_if #(
    parameter int NUM_STAGES = 1,
    parameter int NUM_MIPS   = 12
);
    localparam int STAGE_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int MIPC_W          = $clog2(NUM_MIPS + 1);
    localparam int TEX_ADDR_BITS   = 32;
    localparam int TEX_FORMAT_BITS = 3;
    localparam int TEX_FILTER_BITS = 1;
    localparam int TEX_WRAP_BITS   = 2;
    localparam int TEX_LOD_BITS    = 4;
    localparam int TEX_MIPOFF_BITS = 25;
    localparam int DCR_ADDR_W      = 12;
    localparam int DCR_DATA_W      = 32;

    logic                                req_valid;
    logic                                req_ready;
    logic [STAGE_W-1:0]                  req_stage;
    logic [TEX_ADDR_BITS-1:0]            req_baseaddr;
    logic [TEX_FORMAT_BITS-1:0]          req_format;
    logic [TEX_FILTER_BITS-1:0]          req_filter;
    logic [2*TEX_WRAP_BITS-1:0]          req_wraps;
    logic [2*TEX_LOD_BITS-1:0]           req_logdims;
    logic [NUM_MIPS*TEX_MIPOFF_BITS-1:0] req_mipoff;
    logic [MIPC_W-1:0]                   req_mip_count;

    logic                                host_write_valid;
    logic [DCR_ADDR_W-1:0]               host_write_addr;
    logic [DCR_DATA_W-1:0]               host_write_data;

    logic                                dcr_write_valid;
    logic [DCR_ADDR_W-1:0]               dcr_write_addr;
    logic [DCR_DATA_W-1:0]               dcr_write_data;

    logic                                busy;
    logic                                done;

    modport master (
        output req_valid, req_stage, req_baseaddr, req_format, req_filter,
               req_wraps, req_logdims, req_mipoff, req_mip_count,
               host_write_valid, host_write_addr, host_write_data,
        input  req_ready, dcr_write_valid, dcr_write_addr, dcr_write_data,
               busy, done
    );

    modport slave (
        input  req_valid, req_stage, req_baseaddr, req_format, req_filter,
               req_wraps, req_logdims, req_mipoff, req_mip_count,
               host_write_valid, host_write_addr, host_write_data,
        output req_ready, dcr_write_valid, dcr_write_addr, dcr_write_data,
               busy, done
    );
endinterface

// File: rtl/vx_tex_dcr_seq.sv
// Texture DCR sequencer: expands one packed descriptor into the series of DCR
// writes that program a texture stage. Host writes share the bus and win every
// slot; a host stage-select write mid-sequence forces the captured stage to be
// re-selected before the sequence resumes.
module vx_tex_dcr_seq #(
    parameter int NUM_STAGES = 1,
    parameter int NUM_MIPS   = 12
) (
    input logic             clk,
    input logic             reset_n,
    vx_tex_dcr_seq_if.slave bus
);
    localparam int STAGE_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int MIPC_W          = $clog2(NUM_MIPS + 1);
    localparam int IDX_W           = (NUM_MIPS > 1) ? $clog2(NUM_MIPS) : 1;
    localparam int TEX_ADDR_BITS   = 32;
    localparam int TEX_FORMAT_BITS = 3;
    localparam int TEX_FILTER_BITS = 1;
    localparam int TEX_WRAP_BITS   = 2;
    localparam int TEX_LOD_BITS    = 4;
    localparam int TEX_MIPOFF_BITS = 25;
    localparam int DCR_ADDR_W      = 12;
    localparam int DCR_DATA_W      = 32;

    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_STAGE  = 12'h003;
    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_ADDR   = 12'h004;
    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_LOGDIM = 12'h005;
    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_FORMAT = 12'h006;
    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_FILTER = 12'h007;
    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_WRAP   = 12'h008;
    localparam logic [DCR_ADDR_W-1:0] DCR_TEX_MIPOFF = 12'h009;

    localparam logic [MIPC_W-1:0] NUM_MIPS_C = MIPC_W'(NUM_MIPS);
    localparam logic [MIPC_W-1:0] ONE_C      = MIPC_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_STAGE, S_ADDR, S_FORMAT, S_FILTER, S_WRAP, S_LOGDIM, S_MIP, S_DONE
    } state_t;

    state_t                       state;
    logic [MIPC_W-1:0]            idx;
    logic [MIPC_W-1:0]            mip_cnt;
    logic                         restage;

    logic [STAGE_W-1:0]           stage_q;
    logic [TEX_ADDR_BITS-1:0]     base_q;
    logic [TEX_FORMAT_BITS-1:0]   format_q;
    logic [TEX_FILTER_BITS-1:0]   filter_q;
    logic [2*TEX_WRAP_BITS-1:0]   wraps_q;
    logic [2*TEX_LOD_BITS-1:0]    logdims_q;
    logic [TEX_MIPOFF_BITS-1:0]   mipoff_q [NUM_MIPS];

    logic                         in_seq;
    logic                         host_stage;
    logic                         last_issue;
    logic [MIPC_W-1:0]            req_cnt_clamped;
    logic [DCR_ADDR_W-1:0]        sel_addr;
    logic [DCR_DATA_W-1:0]        sel_data;

    assign req_cnt_clamped = (bus.req_mip_count > NUM_MIPS_C) ? NUM_MIPS_C : bus.req_mip_count;
    assign in_seq          = (state != S_IDLE) && (state != S_DONE);
    assign host_stage      = (bus.host_write_addr == DCR_TEX_STAGE);

    // Detect the slot that issues the final write of the sequence.
    always_comb begin
        last_issue = 1'b0;
        if (!bus.host_write_valid && !restage) begin
            if (state == S_LOGDIM)
                last_issue = (mip_cnt == '0);
            else if (state == S_MIP)
                last_issue = (idx == mip_cnt - ONE_C);
        end
    end

    // Select the sequencer's write for this slot; a pending restage takes precedence.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        if (restage) begin
            sel_addr = DCR_TEX_STAGE;
            sel_data = DCR_DATA_W'(stage_q);
        end else begin
            case (state)
                S_STAGE: begin
                    sel_addr = DCR_TEX_STAGE;
                    sel_data = DCR_DATA_W'(stage_q);
                end
                S_ADDR: begin
                    sel_addr = DCR_TEX_ADDR;
                    sel_data = DCR_DATA_W'(base_q);
                end
                S_FORMAT: begin
                    sel_addr = DCR_TEX_FORMAT;
                    sel_data = DCR_DATA_W'(format_q);
                end
                S_FILTER: begin
                    sel_addr = DCR_TEX_FILTER;
                    sel_data = DCR_DATA_W'(filter_q);
                end
                S_WRAP: begin
                    sel_addr = DCR_TEX_WRAP;
                    sel_data[TEX_WRAP_BITS-1:0]       = wraps_q[TEX_WRAP_BITS-1:0];
                    sel_data[16 +: TEX_WRAP_BITS]     = wraps_q[TEX_WRAP_BITS +: TEX_WRAP_BITS];
                end
                S_LOGDIM: begin
                    sel_addr = DCR_TEX_LOGDIM;
                    sel_data[TEX_LOD_BITS-1:0]        = logdims_q[TEX_LOD_BITS-1:0];
                    sel_data[16 +: TEX_LOD_BITS]      = logdims_q[TEX_LOD_BITS +: TEX_LOD_BITS];
                end
                S_MIP: begin
                    sel_addr = DCR_TEX_MIPOFF + DCR_ADDR_W'(idx);
                    sel_data = DCR_DATA_W'(mipoff_q[IDX_W'(idx)]);
                end
                default: begin
                    sel_addr = '0;
                    sel_data = '0;
                end
            endcase
        end
    end

    // Capture the descriptor fields when a request is accepted.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.req_valid) begin
            stage_q   <= bus.req_stage;
            base_q    <= bus.req_baseaddr;
            format_q  <= bus.req_format;
            filter_q  <= bus.req_filter;
            wraps_q   <= bus.req_wraps;
            logdims_q <= bus.req_logdims;
            mip_cnt   <= req_cnt_clamped;
            for (int i = 0; i < NUM_MIPS; i++)
                mipoff_q[i] <= bus.req_mipoff[i*TEX_MIPOFF_BITS +: TEX_MIPOFF_BITS];
        end
    end

    // Sequencer FSM: stalls on host slots, inserts restage writes, pulses done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            restage       <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        state         <= S_STAGE;
                        idx           <= '0;
                        bus.busy      <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    if (bus.host_write_valid) begin
                        if (host_stage && state != S_STAGE)
                            restage <= 1'b1;
                    end else if (restage) begin
                        restage <= 1'b0;
                    end else begin
                        if (last_issue) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end
                        case (state)
                            S_STAGE:  state <= S_ADDR;
                            S_ADDR:   state <= S_FORMAT;
                            S_FORMAT: state <= S_FILTER;
                            S_FILTER: state <= S_WRAP;
                            S_WRAP:   state <= S_LOGDIM;
                            S_LOGDIM: if (!last_issue) state <= S_MIP;
                            S_MIP:    idx <= idx + ONE_C;
                            default:  state <= state;
                        endcase
                    end
                end
            endcase
        end
    end

    // Registered DCR bus: host write wins the slot, otherwise the sequencer's selection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.dcr_write_valid <= 1'b0;
            bus.dcr_write_addr  <= '0;
            bus.dcr_write_data  <= '0;
        end else if (bus.host_write_valid) begin
            bus.dcr_write_valid <= 1'b1;
            bus.dcr_write_addr  <= bus.host_write_addr;
            bus.dcr_write_data  <= bus.host_write_data;
        end else if (in_seq) begin
            bus.dcr_write_valid <= 1'b1;
            bus.dcr_write_addr  <= sel_addr;
            bus.dcr_write_data  <= sel_data;
        end else begin
            bus.dcr_write_valid <= 1'b0;
        end
    end
endmodule
